// File: rtl/puf_pkg.sv
// Shared PUF definitions: signature geometry and the read/compare FSM states.
// Also consumed by ro_puf_ctrl.
package puf_pkg;

  localparam int PUF_NUM_WORDS = 32;
  localparam int PUF_WORD_W    = 8;
  localparam int PUF_HD_W      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } puf_state_e;

endpackage

// File: rtl/popcount_w.sv
// Combinational population count of one signature word.
module popcount_w #(
  parameter int W = 8
) (
  input  logic [W-1:0]       word,
  output logic [$clog2(W):0] count
);

  localparam int PW = $clog2(W) + 1;

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PW'(word[i]);
    end
  end

endmodule

// File: rtl/puf_sig_reader.sv
// Streams the PUF signature RAM against the golden ROM and reports the
// Hamming distance plus a threshold match once per start request.
module puf_sig_reader
  import puf_pkg::*;
#(
  parameter int NUM_WORDS = PUF_NUM_WORDS,
  parameter int WORD_W    = PUF_WORD_W,
  parameter int RD_LAT    = 1,
  parameter int HD_W      = PUF_HD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [HD_W-1:0]              thresh,
  output logic [$clog2(NUM_WORDS)-1:0] rd_addr,
  output logic                         rd_en,
  input  logic [WORD_W-1:0]            sig_q,
  input  logic [WORD_W-1:0]            gold_q,
  output logic                         busy,
  output logic                         done,
  output logic [HD_W-1:0]              hd,
  output logic                         match
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int PW = $clog2(WORD_W) + 1;

  puf_state_e state, state_nx;

  logic [AW-1:0]     addr_q;
  logic [1:0]        drain_q;
  logic [RD_LAT-1:0] pipe_q;
  logic [HD_W-1:0]   acc_q;
  logic [HD_W-1:0]   acc_nx;
  logic [HD_W-1:0]   thr_q;
  logic [HD_W-1:0]   hd_q;
  logic              match_q;
  logic [PW-1:0]     pc;
  logic              last_addr;
  logic              drain_end;
  logic              accept;

  popcount_w #(.W(WORD_W)) u_pc (
    .word  (sig_q ^ gold_q),
    .count (pc)
  );

  assign last_addr = (addr_q == AW'(NUM_WORDS - 1));
  assign drain_end = (drain_q == 2'(RD_LAT - 1));
  assign accept    = (state == IDLE) && start;
  assign acc_nx    = pipe_q[RD_LAT-1] ? acc_q + HD_W'(pc) : acc_q;

  assign rd_addr = addr_q;
  assign hd      = hd_q;
  assign match   = match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = READ;
      end
      READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (last_addr) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_end) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results are captured on entry to DONE so they are valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      drain_q <= '0;
      pipe_q  <= '0;
      acc_q   <= '0;
      thr_q   <= '0;
      hd_q    <= '0;
      match_q <= 1'b0;
    end else begin
      pipe_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      acc_q <= accept ? '0 : acc_nx;
      if (accept) begin
        addr_q <= '0;
        thr_q  <= thresh;
      end else if (state == READ && !last_addr) begin
        addr_q <= addr_q + AW'(1);
      end
      drain_q <= (state == DRAIN) ? drain_q + 2'd1 : 2'd0;
      if (state_nx == DONE && state != DONE) begin
        hd_q    <= acc_nx;
        match_q <= (acc_nx <= thr_q);
      end
    end
  end

endmodule
